// File: rtl/vend_machine_param.sv
// Parametrised coin vending FSM: credit accumulation, one-cycle release, serial change payout.
// Define VEND_STOCK_EN to add the stock counter, sold_out and restock handling.
module vend_machine_param #(
   parameter int PRICE       = 5,
   parameter int CREDIT_W    = 4,
   parameter int STOCK_DEPTH = 8,
   parameter int STOCK_W     = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                N,
   input  logic                D,
   input  logic                Q,
   input  logic                cancel,
   input  logic                restock,
   output logic                R,
   output logic                N1,
   output logic                D1,
   output logic                coin_rej,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic                sold_out
);
   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] rem_q, rem_d;
   logic                r_q, r_d;
   logic                n1_q, n1_d;
   logic                d1_q, d1_d;
   logic                rej_q, rej_d;
   logic                busy_q;
   logic                sold_q;

   logic [1:0]          coin_cnt;
   logic                any_coin;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] total;
   logic [CREDIT_W-1:0] issue_src;
   logic                issue_en;

   always_comb begin
      coin_cnt  = 2'(N) + 2'(D) + 2'(Q);
      any_coin  = N | D | Q;
      coin_val  = Q ? CREDIT_W'(5) : (D ? CREDIT_W'(2) : CREDIT_W'(1));
      total     = credit_q + coin_val;
      state_d   = state_q;
      credit_d  = credit_q;
      rem_d     = rem_q;
      r_d       = 1'b0;
      n1_d      = 1'b0;
      d1_d      = 1'b0;
      rej_d     = 1'b0;
      issue_en  = 1'b0;
      issue_src = rem_q;

      unique case (state_q)
         IDLE: begin
            if (cancel) begin
               // Cancel beats any coin presented in the same cycle.
               rej_d = any_coin;
               if (credit_q != '0) begin
                  credit_d  = '0;
                  issue_en  = 1'b1;
                  issue_src = credit_q;
                  state_d   = CHANGE;
               end
            end else if (any_coin) begin
               if (coin_cnt != 2'd1 || sold_q) begin
                  rej_d = 1'b1;
               end else if (total < PRICE_C) begin
                  credit_d = total;
               end else begin
                  credit_d = '0;
                  rem_d    = total - PRICE_C;
                  r_d      = 1'b1;
                  state_d  = VEND;
               end
            end
         end
         VEND, CHANGE: begin
            rej_d = any_coin;
            if (rem_q != '0) begin
               issue_en = 1'b1;
               state_d  = CHANGE;
            end else begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Largest coin first: a dime whenever at least two nickels remain.
      if (issue_en) begin
         if (issue_src >= CREDIT_W'(2)) begin
            d1_d  = 1'b1;
            rem_d = issue_src - CREDIT_W'(2);
         end else begin
            n1_d  = 1'b1;
            rem_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         rem_q    <= '0;
         r_q      <= 1'b0;
         n1_q     <= 1'b0;
         d1_q     <= 1'b0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         rem_q    <= rem_d;
         r_q      <= r_d;
         n1_q     <= n1_d;
         d1_q     <= d1_d;
         rej_q    <= rej_d;
         busy_q   <= (state_d != IDLE);
      end
   end

`ifdef VEND_STOCK_EN
   logic [STOCK_W-1:0] stock_q, stock_d;

   // Restock overrides a vend decrement on the same edge.
   always_comb begin
      stock_d = stock_q;
      if (restock) begin
         stock_d = STOCK_W'(STOCK_DEPTH);
      end else if (r_d) begin
         stock_d = stock_q - STOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stock_q <= STOCK_W'(STOCK_DEPTH);
         sold_q  <= 1'b0;
      end else begin
         stock_q <= stock_d;
         sold_q  <= (stock_d == '0);
      end
   end
`else
   logic unused_restock;
   assign unused_restock = restock;
   assign sold_q         = 1'b0;
`endif

   assign R        = r_q;
   assign N1       = n1_q;
   assign D1       = d1_q;
   assign coin_rej = rej_q;
   assign busy     = busy_q;
   assign credit   = credit_q;
   assign sold_out = sold_q;
endmodule

// File: tb/tb_vend_machine_param.sv
// Scoreboard bench for vend_machine_param: a cycle-level reference model queues expected
// outputs per edge; a negedge monitor pops and compares them against the DUT.
module tb_vend_machine_param;
   localparam int PRICE = 5;
   localparam int CW    = 4;
   localparam int SD    = 2;
   localparam int SW    = 4;

`ifdef VEND_STOCK_EN
   localparam bit STOCK_EN = 1'b1;
`else
   localparam bit STOCK_EN = 1'b0;
`endif

   logic          clk;
   logic          reset, N, D, Q, cancel, restock;
   logic          R, N1, D1, coin_rej, busy, sold_out;
   logic [CW-1:0] credit;

   vend_machine_param #(
      .PRICE(PRICE), .CREDIT_W(CW), .STOCK_DEPTH(SD), .STOCK_W(SW)
   ) dut (
      .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
      .restock(restock), .R(R), .N1(N1), .D1(D1), .coin_rej(coin_rej),
      .busy(busy), .credit(credit), .sold_out(sold_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {R, N1, D1, coin_rej, busy, sold_out, credit}
   typedef logic [CW+5:0] vec_t;
   vec_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Reference model: credit as an integer plus a queue of upcoming output cycles.
   int         m_credit = 0;
   int         m_stock  = SD;
   bit         m_busy   = 1'b0;
   logic [2:0] plan[$];          // {R, N1, D1} per future cycle

   task automatic push_change(input int rem);
      for (int i = 0; i < rem / 2; i++) plan.push_back(3'b001);
      if (rem % 2 == 1) plan.push_back(3'b010);
   endtask

   task automatic apply(input bit rst, input bit n, input bit d, input bit q,
                        input bit c, input bit rs);
      int         nc, v, tot;
      bit         rej, sold_before;
      logic [2:0] ent;
      reset = rst; N = n; D = d; Q = q; cancel = c; restock = rs;
      rej = 1'b0;
      ent = 3'b000;
      if (rst) begin
         m_credit = 0;
         plan.delete();
         m_busy   = 1'b0;
         m_stock  = SD;
      end else begin
         nc          = int'(n) + int'(d) + int'(q);
         sold_before = STOCK_EN && (m_stock == 0);
         if (m_busy) begin
            rej = (nc != 0);
         end else if (c) begin
            rej = (nc != 0);
            if (m_credit > 0) begin
               $display("txn cyc=%0d refund credit=%0d", cyc, m_credit);
               push_change(m_credit);
               m_credit = 0;
            end
         end else if (nc != 0) begin
            if (nc > 1 || sold_before) begin
               rej = 1'b1;
            end else begin
               v   = q ? 5 : (d ? 2 : 1);
               tot = m_credit + v;
               if (tot < PRICE) begin
                  m_credit = tot;
               end else begin
                  $display("txn cyc=%0d vend total=%0d change=%0d", cyc, tot, tot - PRICE);
                  m_credit = 0;
                  plan.push_back(3'b100);
                  push_change(tot - PRICE);
                  if (STOCK_EN) m_stock = m_stock - 1;
               end
            end
         end
         if (STOCK_EN && rs) m_stock = SD;
         if (plan.size() > 0) begin
            ent    = plan.pop_front();
            m_busy = 1'b1;
         end else begin
            m_busy = 1'b0;
         end
      end
      exp_q.push_back({ent, rej, m_busy, (STOCK_EN && m_stock == 0), CW'(m_credit)});
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) apply(0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one comparison per DUT output cycle.
   initial begin
      vec_t e, got;
      int   mcyc;
      mcyc = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {R, N1, D1, coin_rej, busy, sold_out, credit};
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL outputs cyc=%0d got R,N1,D1,rej,busy,sold=%b credit=%0d want %b credit=%0d",
                        mcyc, got[CW+5:CW], got[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            mcyc++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bit rr_rst, rr_n, rr_d, rr_q, rr_c, rr_rs;
      reset = 1'b1; N = 0; D = 0; Q = 0; cancel = 0; restock = 0;
      apply(1, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0);
      // Q alone vends with no change
      apply(0, 0, 0, 1, 0, 0); idle(3);
      // D, D, Q -> R then two dimes
      apply(0, 0, 1, 0, 0, 0); apply(0, 0, 1, 0, 0, 0); apply(0, 0, 0, 1, 0, 0); idle(4);
      // N, D, cancel -> dime then nickel refund
      apply(0, 1, 0, 0, 0, 0); apply(0, 0, 1, 0, 0, 0); apply(0, 0, 0, 0, 1, 0); idle(3);
      // coin during VEND is rejected
      apply(0, 0, 0, 1, 0, 0); apply(0, 1, 0, 0, 0, 0); idle(3);
      // two coins together in IDLE are rejected, credit kept
      apply(0, 1, 0, 0, 0, 0); apply(0, 1, 1, 0, 0, 0); apply(0, 0, 0, 0, 1, 0); idle(2);
      // reset mid-accumulation, then a normal vend
      apply(0, 1, 0, 0, 0, 0); apply(1, 0, 0, 0, 0, 0); idle(1);
      apply(0, 0, 0, 1, 0, 0); idle(2);
      // cancel with a coin in the same cycle: coin rejected, credit refunded
      apply(0, 0, 1, 0, 0, 0); apply(0, 0, 0, 1, 1, 0); idle(2);
      // cancel with zero credit has no effect
      apply(0, 0, 0, 0, 1, 0); idle(1);
      // stock exhaustion and restock (plain vends without the stock feature)
      apply(0, 0, 0, 1, 0, 0); idle(1); apply(0, 0, 0, 1, 0, 0); idle(1);
      apply(0, 0, 0, 1, 0, 0); idle(1);
      apply(0, 0, 0, 0, 0, 1); apply(0, 0, 0, 1, 0, 0); idle(2);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rr_rst = ($urandom_range(0, 99) == 0);
         rr_n   = ($urandom_range(0, 99) < 20);
         rr_d   = ($urandom_range(0, 99) < 20);
         rr_q   = ($urandom_range(0, 99) < 12);
         rr_c   = ($urandom_range(0, 99) < 6);
         rr_rs  = ($urandom_range(0, 99) < 4);
         apply(rr_rst, rr_n, rr_d, rr_q, rr_c, rr_rs);
      end
      idle(4);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vend_machine_param.md
Name: vend_machine_param

Overview:
Parametrised successor to the single-price newspaper vending FSM. It accepts nickel, dime and quarter strobes and accumulates credit in nickel units against a programmable PRICE. When credit reaches PRICE it issues a one-cycle release pulse, then pays change serially, one coin per cycle, largest coin first. It also adds cancel/refund, rejection of coins while busy or invalid, and optional stock tracking.

Parameters:
PRICE, 5, item price in nickel units (5 = 25 cents); legal range 1..(2**CREDIT_W - 5)
CREDIT_W, 4, width of credit/remainder registers; must hold PRICE+4
STOCK_DEPTH, 8, items loaded on reset/restock (used only with VEND_STOCK_EN)
STOCK_W, 4, width of stock counter; must hold STOCK_DEPTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
N  input  1  nickel inserted strobe (1 cycle per coin)
D  input  1  dime inserted strobe
Q  input  1  quarter inserted strobe
cancel  input  1  refund request
R  output  1  release item, 1-cycle pulse
N1  output  1  return one nickel, 1-cycle pulse
D1  output  1  return one dime, 1-cycle pulse
coin_rej  output  1  coin sampled this edge was rejected (returned to user), 1-cycle pulse
busy  output  1  state is not IDLE
credit  output  CREDIT_W  accumulated credit, nickel units
sold_out  output  1  stock exhausted (constant 0 without VEND_STOCK_EN)
restock  input  1  reload stock to STOCK_DEPTH (ignored without VEND_STOCK_EN)

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. On reset: state=IDLE; credit=0; rem=0; R, N1, D1 and coin_rej = 0; busy=0; stock=STOCK_DEPTH; sold_out=0.
- Reset mid-vend or mid-change aborts immediately. Credit and remainder are lost and no further pulses are issued.
- All outputs are registered. Coin value per strobe: N=1, D=2, Q=5.
- States: IDLE, VEND, CHANGE.
- IDLE, coin accepted (exactly one of N/D/Q high, cancel=0, not sold_out):
  - total = credit + value.
  - If total < PRICE: credit <= total, stay IDLE.
  - Else: credit <= 0, rem <= total - PRICE, R <= 1, next state VEND.
- IDLE, cancel=1 and credit>0: rem <= credit, credit <= 0, next state CHANGE via the first-coin rule below. R is never asserted on this path.
- IDLE, cancel=1 and credit=0: no effect.
- Cancel and a coin in the same cycle: cancel wins; the coin is rejected (coin_rej=1).
- Rejections, each giving a coin_rej pulse with credit unchanged:
  - more than one of N/D/Q high in a cycle;
  - any coin while busy (VEND or CHANGE);
  - any coin while sold_out.
- VEND lasts exactly 1 cycle, with R=1 during it.
  - rem=0 -> IDLE.
  - rem>0 -> CHANGE, issuing the first coin on the same edge.
- Coin issue rule, applied on each edge that issues a coin:
  - rem >= 2: D1 <= 1, rem <= rem - 2.
  - rem = 1: N1 <= 1, rem <= 0.
  - N1 and D1 are never high together.
- CHANGE: on each edge, if rem>0 issue the next coin and stay; if rem=0 clear N1/D1 and go to IDLE.
- Change latency = ceil(rem/2) cycles. For PRICE=5 the maximum rem is 4 (credit 4 + Q), i.e. 2 dimes.
- busy=1 exactly while state is VEND or CHANGE.
- Credit never exceeds PRICE-1 in IDLE; no wrap-around is possible with legal parameters.

Optional Feature:
VEND_STOCK_EN.
- Defined: a stock counter of STOCK_W bits loads STOCK_DEPTH on reset. It decrements by 1 on every edge that asserts R. sold_out = (stock==0), registered.
- While sold_out, all coins are rejected; cancel still refunds any residual credit.
- restock=1 (sampled in any state) reloads STOCK_DEPTH; sold_out clears on the next cycle.
- restock and a vend on the same edge: restock wins and stock = STOCK_DEPTH.
- Undefined: no counter; sold_out tied to 0; restock ignored.

Test Plan:
- Reset, then Q alone (PRICE=5) -> R=1 for 1 cycle the next cycle, no N1/D1, credit=0, busy for 1 cycle.
- D, D (credit=4), then Q -> R cycle, then D1, then D1, then IDLE; busy for 3 cycles; credit=0.
- N, D (credit=3), then cancel -> D1 cycle, then N1 cycle, R never high, credit=0.
- Q followed by N on the next cycle (during VEND) -> coin_rej=1 in the cycle after the N strobe, credit stays 0; N and D high together in IDLE -> coin_rej=1, credit unchanged.
- N, then reset asserted in the following cycle, then reset deasserted -> credit=0, no R/N1/D1 pulses; next Q vends normally.
- VEND_STOCK_EN, STOCK_DEPTH=2: Q, Q -> two R pulses, sold_out=1; third Q -> coin_rej=1, no R; restock=1 -> sold_out=0, next Q vends.
